// File: rtl/ysyx_22050854_div_unit.sv
// ============================================================================
// Module   : ysyx_22050854_div_unit
// Purpose  : 64/32-bit signed/unsigned restoring divider, one quotient bit per cycle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050854_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic        div_valid,
    input  logic        divw,
    input  logic        div_signed,
    output logic        div_doing,
    output logic        div_ready,
    output logic        out_valid,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q;
    logic [63:0] a_prep_q, b_mag_q, rem_q, quot_q;
    logic        divw_q, neg_q_q, neg_r_q, zero_q, ovf_q;
    logic [63:0] quotient_q, remainder_q;
    logic        out_valid_q;

    logic        accept, last_iter;
    logic [63:0] a_prep, b_prep, a_mag, b_mag;
    logic        a_neg, b_neg, b_zero, ovf;
    logic [64:0] rem_shift;
    logic        ge;
    logic [63:0] rem_next;
    logic [63:0] q_mag, q_sgn, r_sgn, res_q, res_r;

    // Operand preparation, evaluated on the live inputs and captured at accept
    always_comb begin
        a_prep = dividend;
        b_prep = divisor;
        if (divw) begin
            a_prep = {{32{div_signed & dividend[31]}}, dividend[31:0]};
            b_prep = {{32{div_signed & divisor[31]}},  divisor[31:0]};
        end
        a_neg  = div_signed & a_prep[63];
        b_neg  = div_signed & b_prep[63];
        a_mag  = a_neg ? (~a_prep + 64'd1) : a_prep;
        b_mag  = b_neg ? (~b_prep + 64'd1) : b_prep;
        b_zero = (b_prep == 64'd0);
        ovf    = div_signed && (b_prep == {64{1'b1}}) &&
                 (a_prep == (divw ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    end

    always_comb begin
        state_d   = state_q;
        div_ready = (state_q == S_IDLE);
        div_doing = (state_q == S_CALC);
        accept    = div_valid && (state_q == S_IDLE);
        last_iter = (cnt_q == (divw_q ? 7'd31 : 7'd63));
        case (state_q)
            S_IDLE:  if (div_valid) state_d = S_CALC;
            S_CALC:  if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Restoring step: the partial remainder always stays below the divisor,
    // so the difference fits back into 64 bits.
    always_comb begin
        rem_shift = {rem_q, quot_q[63]};
        ge        = (rem_shift >= {1'b0, b_mag_q});
        rem_next  = ge ? (rem_shift[63:0] - b_mag_q) : rem_shift[63:0];
    end

    always_comb begin
        q_mag = divw_q ? {32'd0, quot_q[31:0]} : quot_q;
        q_sgn = neg_q_q ? (~q_mag + 64'd1) : q_mag;
        r_sgn = neg_r_q ? (~rem_q + 64'd1) : rem_q;
        res_q = q_sgn;
        res_r = r_sgn;
        if (zero_q) begin
            res_q = {64{1'b1}};
            res_r = a_prep_q;
        end else if (ovf_q) begin
            res_q = a_prep_q;
            res_r = 64'd0;
        end
        if (divw_q) begin
            res_q = {{32{res_q[31]}}, res_q[31:0]};
            res_r = {{32{res_r[31]}}, res_r[31:0]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 7'd0;
            a_prep_q    <= 64'd0;
            b_mag_q     <= 64'd0;
            rem_q       <= 64'd0;
            quot_q      <= 64'd0;
            divw_q      <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= 64'd0;
            remainder_q <= 64'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_q == S_DONE);
            if (accept) begin
                a_prep_q <= a_prep;
                b_mag_q  <= b_mag;
                rem_q    <= 64'd0;
                // 32-bit magnitudes sit in the top half so both widths shift out of bit 63
                quot_q   <= divw ? {a_mag[31:0], 32'd0} : a_mag;
                cnt_q    <= 7'd0;
                divw_q   <= divw;
                neg_q_q  <= a_neg ^ b_neg;
                neg_r_q  <= a_neg;
                zero_q   <= b_zero;
                ovf_q    <= ovf;
            end else if (state_q == S_CALC) begin
                rem_q  <= rem_next;
                quot_q <= {quot_q[62:0], ge};
                cnt_q  <= cnt_q + 7'd1;
            end
            if (state_q == S_DONE) begin
                quotient_q  <= res_q;
                remainder_q <= res_r;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

`default_nettype wire
